// File: rtl/grey_seq_ctrl_if.sv
// Stream and control bundle for grey_seq_ctrl. The "master" side is the sequencer;
// the "slave" side is the controller/consumer. err exists only with GREY_SEQ_STEP_CHECK_EN.
interface grey_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             dir;
  logic             wrap_en;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] grey_out;
  logic             busy;
  logic             done;
`ifdef GREY_SEQ_STEP_CHECK_EN
  logic             err;
`endif

  modport master (
    input  start, stop, dir, wrap_en, out_ready,
`ifdef GREY_SEQ_STEP_CHECK_EN
    output err,
`endif
    output out_valid, bin_out, grey_out, busy, done
  );

  modport slave (
    output start, stop, dir, wrap_en, out_ready,
`ifdef GREY_SEQ_STEP_CHECK_EN
    input  err,
`endif
    input  out_valid, bin_out, grey_out, busy, done
  );
endinterface

// File: rtl/grey_seq_ctrl.sv
// Sweeps a binary index over [0, LIMIT] up or down as a valid/ready stream with its grey code.
// Optional feature: GREY_SEQ_STEP_CHECK_EN adds a sticky err flag for multi-bit grey steps.
module grey_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 9
) (
  input  logic               clk,
  input  logic               rst,
  grey_seq_ctrl_if.master    seq_if
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] grey_q, grey_d;
  logic             dir_q, dir_d;
  logic             accept;
  logic             terminal;

  assign accept   = (state_q == RUN) && seq_if.out_ready;
  assign terminal = dir_q ? (bin_q == '0) : (bin_q == LIMIT_V);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (seq_if.start && !seq_if.stop) begin
          state_d = RUN;
          dir_d   = seq_if.dir;
          bin_d   = seq_if.dir ? LIMIT_V : '0;
        end
      end
      RUN: begin
        // A beat accepted alongside stop is delivered, but the index does not advance.
        if (seq_if.stop) begin
          state_d = IDLE;
        end else if (accept) begin
          if (!terminal)            bin_d = dir_q ? (bin_q - ONE_V) : (bin_q + ONE_V);
          else if (seq_if.wrap_en)  bin_d = dir_q ? LIMIT_V : '0;
          else                      state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    grey_d = bin_d ^ (bin_d >> 1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      grey_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      grey_q  <= grey_d;
      dir_q   <= dir_d;
    end
  end

  assign seq_if.out_valid = (state_q == RUN);
  assign seq_if.busy      = (state_q == RUN);
  assign seq_if.done      = (state_q == DONE);
  assign seq_if.bin_out   = bin_q;
  assign seq_if.grey_out  = grey_q;

`ifdef GREY_SEQ_STEP_CHECK_EN
  localparam logic FULL_RANGE = (LIMIT_V == {WIDTH{1'b1}});

  logic [WIDTH-1:0] prev_grey_q, prev_grey_d;
  logic             prev_ok_q, prev_ok_d;
  logic             prev_term_q, prev_term_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] step_diff;
  logic             one_bit;

  assign step_diff = prev_grey_q ^ grey_q;
  assign one_bit   = (step_diff != '0) && ((step_diff & (step_diff - ONE_V)) == '0);

  always_comb begin
    prev_grey_d = prev_grey_q;
    prev_ok_d   = prev_ok_q;
    prev_term_d = prev_term_q;
    err_d       = err_q;
    if (state_q == IDLE && seq_if.start && !seq_if.stop) begin
      prev_ok_d = 1'b0;
    end else if (accept) begin
      // A wrap on a partial range legitimately jumps more than one grey bit.
      if (prev_ok_q && !one_bit && !(prev_term_q && !FULL_RANGE)) err_d = 1'b1;
      prev_ok_d   = 1'b1;
      prev_grey_d = grey_q;
      prev_term_d = terminal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_grey_q <= '0;
      prev_ok_q   <= 1'b0;
      prev_term_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_grey_q <= prev_grey_d;
      prev_ok_q   <= prev_ok_d;
      prev_term_q <= prev_term_d;
      err_q       <= err_d;
    end
  end

  assign seq_if.err = err_q;
`endif

endmodule

// File: tb/tb_grey_seq_ctrl.sv
// Directed plus random stimulus for grey_seq_ctrl (WIDTH=4, LIMIT=9) against a
// beat-position model: the k-th accepted beat of a sweep is k mod (LIMIT+1), mirrored for down.
module tb_grey_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int LIMIT = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grey_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  grey_seq_ctrl #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_run, m_done, m_dir;
  int m_pos, m_bin;
  bit acc_ok;
  int acc_bin;
  logic [WIDTH-1:0] acc_grey;

  logic [3:0] gtab [10] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int beat(input int pos, input bit d);
    return d ? (LIMIT - (pos % (LIMIT + 1))) : (pos % (LIMIT + 1));
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_dir = 0; m_pos = 0; m_bin = 0; acc_ok = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_run));
    check({tag, ".busy"},      32'(bus.busy),      32'(m_run));
    check({tag, ".done"},      32'(bus.done),      32'(m_done));
    check({tag, ".bin_out"},   32'(bus.bin_out),   32'(m_bin));
    check({tag, ".grey_out"},  32'(bus.grey_out),  32'(m_bin ^ (m_bin >> 1)));
`ifdef GREY_SEQ_STEP_CHECK_EN
    check({tag, ".err"},       32'(bus.err),       32'd0);
`endif
  endtask

  // Advance the model by one clock using the currently driven inputs, then compare.
  task automatic tick(input string tag);
    bit term;
    if (bus.out_valid === 1'b1 && bus.out_ready) begin
      term = m_dir ? (acc_bin == 0) : (acc_bin == LIMIT);
      if (acc_ok && !term)
        check({tag, ".grey_step"}, 32'($countones(acc_grey ^ bus.grey_out)), 32'd1);
      acc_ok   = 1;
      acc_bin  = int'(bus.bin_out);
      acc_grey = bus.grey_out;
    end
    if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (bus.start && !bus.stop) begin
        m_run = 1; m_dir = bus.dir; m_pos = 0; m_bin = beat(0, bus.dir); acc_ok = 0;
      end
    end else if (bus.stop) begin
      m_run = 0;
    end else if (bus.out_ready) begin
      if ((m_pos % (LIMIT + 1)) == LIMIT && !bus.wrap_en) begin
        m_run = 0; m_done = 1;
      end else begin
        m_pos++;
        m_bin = beat(m_pos, m_dir);
      end
    end
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input bit s, input bit p, input bit d, input bit w, input bit r);
    bus.start = s; bus.stop = p; bus.dir = d; bus.wrap_en = w; bus.out_ready = r;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;

    // Sweep up to index 5, then assert reset asynchronously mid-cycle
    drive(1, 0, 0, 0, 1);
    tick("t1_start");
    bus.start = 0;
    for (int i = 0; i < 20 && m_bin != 5; i++) tick("t1_run");
    check("t1_reached5", 32'(bus.bin_out), 32'd5);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("t1_async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all("t1_after_rst");

    // Full up sweep against the literal grey table
    drive(1, 0, 0, 0, 1);
    tick("t2_start");
    bus.start = 0;
    for (int k = 0; k < 10; k++) begin
      check("t2_grey_tab", 32'(bus.grey_out), 32'(gtab[k]));
      tick("t2_run");
    end
    check("t2_done", 32'(bus.done), 32'd1);
    tick("t2_idle");
    check("t2_idle_done", 32'(bus.done), 32'd0);

    // Down sweep with toggling ready
    drive(1, 0, 1, 0, 1);
    tick("t3_start");
    bus.start = 0;
    for (int i = 0; i < 40 && (m_run || m_done); i++) begin
      bus.out_ready = ~bus.out_ready;
      tick("t3_run");
    end

    // Wrapping up sweep: no bubble, no done
    drive(1, 0, 0, 1, 1);
    tick("t4_start");
    bus.start = 0;
    for (int i = 0; i < 25; i++) tick("t4_wrap");

    // Stop at index 4 with ready high
    drive(1, 0, 0, 0, 1);
    bus.stop = 1;
    tick("t4_stop_restart");
    bus.stop = 0;
    tick("t5_start");
    bus.start = 0;
    for (int i = 0; i < 20 && m_bin != 4; i++) tick("t5_run");
    bus.stop = 1;
    tick("t5_stop");
    bus.stop = 0;
    check("t5_hold4", 32'(bus.bin_out), 32'd4);

    // start with stop in IDLE; start during RUN
    drive(1, 1, 0, 0, 1);
    tick("t6_start_stop");
    tick("t6_start_stop2");
    bus.stop = 0;
    tick("t6_start");
    for (int i = 0; i < 5; i++) tick("t6_start_in_run");
    bus.start = 0;
    for (int i = 0; i < 12; i++) tick("t6_finish");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3) == 0), ($urandom_range(19) == 0), 1'($urandom),
            ($urandom_range(2) == 0), ($urandom_range(3) != 0));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
